// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, FSM encoding and S-box helpers
package aes_pkg;

    localparam int AES_DATA_W = 128;
    localparam int AES_NR     = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Round r uses RCON[r-1]; anything outside 1..10 yields zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        logic [7:0] r;
        r = 8'h00;
        if (rnd >= 4'd1 && rnd <= 4'd10) begin
            r = RCON[int'(rnd) - 1];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - one combinational AES-128 key-schedule step
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = key_in[127:96];
    assign w1 = key_in[95:64];
    assign w2 = key_in[63:32];
    assign w3 = key_in[31:0];

    assign temp = sub_word(rot_word(w3)) ^ {rcon, 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 encryption sequencer
// Drives an external round datapath one round per cycle and holds the result.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int DATA_W = AES_DATA_W,
    parameter int NR     = AES_NR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pt,
    input  logic [DATA_W-1:0] in_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_ct,
    output logic [DATA_W-1:0] rnd_state,
    output logic [DATA_W-1:0] rnd_key,
    output logic              rnd_last,
    input  logic [DATA_W-1:0] rnd_result,
    output logic              busy
);

    state_e            fsm_q, fsm_d;
    logic [DATA_W-1:0] state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [3:0]        rnd_q, rnd_d;
    logic [DATA_W-1:0] step_key;
    logic              last_round;

    aes_key_step u_key_step (
        .key_in  (key_q),
        .rcon    (rcon_of(rnd_q)),
        .key_out (step_key)
    );

    assign last_round = (rnd_q == 4'(NR));

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        key_d     = key_q;
        rnd_d     = rnd_q;
        rnd_key   = key_q;
        rnd_last  = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = in_pt ^ in_key;
                    key_d   = in_key;
                    rnd_d   = 4'd1;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                rnd_key  = step_key;
                rnd_last = last_round;
                state_d  = rnd_result;
                key_d    = step_key;
                // rnd_q stays at NR in DONE so it never wraps.
                if (last_round) begin
                    fsm_d = ST_DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = (fsm_q == ST_RUN);
    assign out_ct    = state_q;
    assign rnd_state = state_q;

endmodule
